// File: rtl/msg_sim_pkg.sv
// Shared types, beat geometry, header field positions and length helpers for
// the synthetic upstream message generator.
package msg_sim_pkg;

  localparam int BEAT_BYTES = 16;
  localparam int BEAT_W     = 128;

  // LSB position of each header field inside the 128-bit header beat
  localparam int HDR_SYNC_LSB  = 96;  // 32 bits
  localparam int HDR_LEN_LSB   = 80;  // 16 bits
  localparam int HDR_TYPE_LSB  = 76;  //  4 bits
  localparam int HDR_RSVD_LSB  = 64;  // 12 bits, always zero
  localparam int HDR_CNT_LSB   = 48;  // 16 bits
  localparam int HDR_SRC_LSB   = 40;  //  8 bits
  localparam int HDR_DES_LSB   = 32;  //  8 bits
  localparam int HDR_DTYPE_LSB = 24;  //  8 bits
  localparam int HDR_CHAN_LSB  = 16;  //  8 bits
  localparam int HDR_FLEN_LSB  = 0;   // 16 bits

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HEADER    = 2'd1,
    PAYLOAD   = 2'd2,
    DONE_WAIT = 2'd3
  } state_e;

  // Frame configuration captured at the start edge
  typedef struct packed {
    logic [31:0] sync;
    logic [15:0] frame_len;
    logic [3:0]  frame_type;
    logic [15:0] frame_cnt;
    logic [7:0]  src_id;
    logic [7:0]  des_id;
    logic [7:0]  data_type;
    logic [7:0]  data_channel;
    logic [15:0] field_len;
  } cfg_t;

  // Payload beat count: ceil(field_len/16), at most 4096
  function automatic logic [12:0] calc_beats(input logic [15:0] field_len);
    return 13'((17'(field_len) + 17'd15) >> 4);
  endfunction

  // Auto frame length: one header beat plus the payload beats, in bytes
  function automatic logic [15:0] calc_auto_len(input logic [12:0] beats);
    return 16'(17'd16 + {beats, 4'b0000});
  endfunction

endpackage

// File: rtl/msg_transmit_simulation.sv
// Synthetic upstream frame generator: on a rising edge of msg_sim_en_i emits
// one header beat followed by ceil(field_len/16) counting-pattern payload beats,
// pulsing done with the last beat. Dropping the enable mid-frame aborts.
module msg_transmit_simulation
  import msg_sim_pkg::*;
#(
  parameter logic [7:0] PAYLOAD_SEED = 8'h00
) (
  input  logic              sys_clk_i,
  input  logic              rst_n_i,
  input  logic              msg_sim_en_i,
  output logic              msg_done_pluse_o,
  input  logic [31:0]       sim_frame_header,
  input  logic [15:0]       sim_frame_len,
  input  logic [3:0]        sim_frame_type,
  input  logic [15:0]       sim_frame_cnt,
  input  logic [7:0]        sim_src_id,
  input  logic [7:0]        sim_des_id,
  input  logic [7:0]        sim_data_type,
  input  logic [7:0]        sim_data_channel,
  input  logic [15:0]       sim_data_field_len,
  output logic              msg_sim_vld_o,
  output logic [BEAT_W-1:0] msg_sim_data_o
);

  state_e            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [12:0]       beat_idx_q, beat_idx_d;
  logic              en_q, en_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;
  logic [BEAT_W-1:0] data_q, data_d;

  logic [12:0]       num_beats;
  logic [15:0]       hdr_len;

  assign num_beats = calc_beats(cfg_q.field_len);
  assign hdr_len   = (cfg_q.frame_len != 16'h0000) ? cfg_q.frame_len
                                                   : calc_auto_len(num_beats);

  function automatic logic [BEAT_W-1:0] header_beat(input cfg_t c,
                                                    input logic [15:0] len);
    logic [BEAT_W-1:0] b;
    b = '0;
    b[HDR_SYNC_LSB  +: 32] = c.sync;
    b[HDR_LEN_LSB   +: 16] = len;
    b[HDR_TYPE_LSB  +: 4]  = c.frame_type;
    b[HDR_RSVD_LSB  +: 12] = 12'h000;
    b[HDR_CNT_LSB   +: 16] = c.frame_cnt;
    b[HDR_SRC_LSB   +: 8]  = c.src_id;
    b[HDR_DES_LSB   +: 8]  = c.des_id;
    b[HDR_DTYPE_LSB +: 8]  = c.data_type;
    b[HDR_CHAN_LSB  +: 8]  = c.data_channel;
    b[HDR_FLEN_LSB  +: 16] = c.field_len;
    return b;
  endfunction

  // Byte k of the payload is SEED+k; lanes past field_len are zero-filled.
  function automatic logic [BEAT_W-1:0] payload_beat(input logic [12:0] idx,
                                                     input logic [15:0] field_len);
    logic [BEAT_W-1:0] b;
    logic [16:0]       k;
    b = '0;
    for (int l = 0; l < BEAT_BYTES; l++) begin
      k = {idx, 4'b0000} + 17'(l);
      if (k < {1'b0, field_len}) begin
        b[BEAT_W-1-8*l -: 8] = PAYLOAD_SEED + k[7:0];
      end
    end
    return b;
  endfunction

  // Next-state and next-output computation for the frame sequencer
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    cfg_d      = cfg_q;
    beat_idx_d = beat_idx_q;
    en_d       = msg_sim_en_i;
    vld_d      = 1'b0;
    done_d     = 1'b0;
    data_d     = '0;

    unique case (state_q)
      IDLE: begin
        if (msg_sim_en_i && !en_q) begin
          cfg_d = '{sync:         sim_frame_header,
                    frame_len:    sim_frame_len,
                    frame_type:   sim_frame_type,
                    frame_cnt:    sim_frame_cnt,
                    src_id:       sim_src_id,
                    des_id:       sim_des_id,
                    data_type:    sim_data_type,
                    data_channel: sim_data_channel,
                    field_len:    sim_data_field_len};
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (!msg_sim_en_i) begin
          state_d = IDLE;
        end else begin
          vld_d  = 1'b1;
          data_d = header_beat(cfg_q, hdr_len);
          if (num_beats != 13'd0) begin
            beat_idx_d = 13'd0;
            state_d    = PAYLOAD;
          end else begin
            done_d  = 1'b1;
            state_d = DONE_WAIT;
          end
        end
      end
      PAYLOAD: begin
        if (!msg_sim_en_i) begin
          state_d = IDLE;
        end else begin
          vld_d  = 1'b1;
          data_d = payload_beat(beat_idx_q, cfg_q.field_len);
          if (beat_idx_q == num_beats - 13'd1) begin
            done_d  = 1'b1;
            state_d = DONE_WAIT;
          end else begin
            beat_idx_d = beat_idx_q + 13'd1;
          end
        end
      end
      DONE_WAIT: begin
        if (!msg_sim_en_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured configuration and registered outputs
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the captured configuration is reset too; it is only a few flops
      // and keeps the header deterministic after reset.
      state_q    <= IDLE;
      cfg_q      <= '0;
      beat_idx_q <= '0;
      en_q       <= 1'b0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      beat_idx_q <= beat_idx_d;
      en_q       <= en_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      data_q     <= data_d;
    end
  end

  assign msg_sim_vld_o    = vld_q;
  assign msg_sim_data_o   = data_q;
  assign msg_done_pluse_o = done_q;

endmodule

// File: tb/tb_msg_transmit_simulation.sv
// Directed bench for msg_transmit_simulation: table of frame configurations
// with hand-computed header and last beats, plus abort, reset and retrigger
// sequences.
module tb_msg_transmit_simulation;

  logic         sys_clk_i = 1'b0;
  logic         rst_n_i;
  logic         msg_sim_en_i;
  logic         msg_done_pluse_o;
  logic [31:0]  sim_frame_header;
  logic [15:0]  sim_frame_len;
  logic [3:0]   sim_frame_type;
  logic [15:0]  sim_frame_cnt;
  logic [7:0]   sim_src_id;
  logic [7:0]   sim_des_id;
  logic [7:0]   sim_data_type;
  logic [7:0]   sim_data_channel;
  logic [15:0]  sim_data_field_len;
  logic         msg_sim_vld_o;
  logic [127:0] msg_sim_data_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk_i = ~sys_clk_i;

  msg_transmit_simulation dut (
    .sys_clk_i          (sys_clk_i),
    .rst_n_i            (rst_n_i),
    .msg_sim_en_i       (msg_sim_en_i),
    .msg_done_pluse_o   (msg_done_pluse_o),
    .sim_frame_header   (sim_frame_header),
    .sim_frame_len      (sim_frame_len),
    .sim_frame_type     (sim_frame_type),
    .sim_frame_cnt      (sim_frame_cnt),
    .sim_src_id         (sim_src_id),
    .sim_des_id         (sim_des_id),
    .sim_data_type      (sim_data_type),
    .sim_data_channel   (sim_data_channel),
    .sim_data_field_len (sim_data_field_len),
    .msg_sim_vld_o      (msg_sim_vld_o),
    .msg_sim_data_o     (msg_sim_data_o)
  );

  typedef struct {
    string        name;
    logic [31:0]  sync;
    logic [15:0]  frame_len;
    logic [3:0]   frame_type;
    logic [15:0]  frame_cnt;
    logic [7:0]   src, des, dtype, chan;
    logic [15:0]  field_len;
    int           beats;     // payload beats P
    logic [127:0] exp_hdr;
    logic [127:0] exp_last;  // last valid beat (header when P=0)
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] actual,
                       input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic apply_cfg(input vec_t v);
    sim_frame_header   = v.sync;
    sim_frame_len      = v.frame_len;
    sim_frame_type     = v.frame_type;
    sim_frame_cnt      = v.frame_cnt;
    sim_src_id         = v.src;
    sim_des_id         = v.des;
    sim_data_type      = v.dtype;
    sim_data_channel   = v.chan;
    sim_data_field_len = v.field_len;
  endtask

  // Start a frame, follow it cycle by cycle, hold enable high afterwards,
  // then drop enable so the sequencer returns to idle.
  task automatic run_frame(input vec_t v);
    apply_cfg(v);
    msg_sim_en_i = 1'b1;
    tick();  // start edge: nothing visible yet
    check({v.name, " start vld"}, 128'(msg_sim_vld_o), 128'd0);
    // Inputs scrambled after the start edge must not leak into the frame
    sim_frame_header   = ~v.sync;
    sim_frame_len      = 16'hbeef;
    sim_src_id         = ~v.src;
    sim_data_field_len = 16'hffff;
    for (int i = 1; i <= v.beats + 1; i++) begin
      tick();
      check($sformatf("%s beat%0d vld", v.name, i - 1), 128'(msg_sim_vld_o), 128'd1);
      check($sformatf("%s beat%0d done", v.name, i - 1), 128'(msg_done_pluse_o),
            128'(i == v.beats + 1));
      if (i == 1) check({v.name, " header"}, msg_sim_data_o, v.exp_hdr);
      if (i == v.beats + 1) check({v.name, " last beat"}, msg_sim_data_o, v.exp_last);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("%s hold%0d vld/done", v.name, i),
            {126'd0, msg_sim_vld_o, msg_done_pluse_o}, 128'd0);
      check($sformatf("%s hold%0d data", v.name, i), msg_sim_data_o, 128'd0);
    end
    msg_sim_en_i = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    vecs[0] = '{"autolen16", 32'hfdf7_eb90, 16'h0000, 4'h4, 16'heb90, 8'h12, 8'h00,
                8'h34, 8'h56, 16'd16, 1,
                128'hfdf7eb90_0020_4000_eb90_12003456_0010,
                128'h00010203_04050607_08090a0b_0c0d0e0f};
    vecs[1] = '{"zeropay", 32'hfdf7_eb90, 16'h0000, 4'h4, 16'heb90, 8'h12, 8'h00,
                8'h34, 8'h56, 16'd0, 0,
                128'hfdf7eb90_0010_4000_eb90_12003456_0000,
                128'hfdf7eb90_0010_4000_eb90_12003456_0000};
    vecs[2] = '{"partial20", 32'hfdf7_eb90, 16'h0000, 4'h4, 16'heb90, 8'h12, 8'h00,
                8'h34, 8'h56, 16'd20, 2,
                128'hfdf7eb90_0030_4000_eb90_12003456_0014,
                128'h10111213_00000000_00000000_00000000};
    vecs[3] = '{"explen", 32'h0102_0304, 16'h1234, 4'ha, 16'h0001, 8'hab, 8'hcd,
                8'hef, 8'h01, 16'd3, 1,
                128'h01020304_1234_a000_0001_abcdef01_0003,
                128'h00010200_00000000_00000000_00000000};
    vecs[4] = '{"len33", 32'hfdf7_eb90, 16'h0000, 4'h4, 16'heb90, 8'h12, 8'h00,
                8'h34, 8'h56, 16'd33, 3,
                128'hfdf7eb90_0040_4000_eb90_12003456_0021,
                128'h20000000_00000000_00000000_00000000};

    rst_n_i      = 1'b0;
    msg_sim_en_i = 1'b0;
    apply_cfg(vecs[0]);
    tick();
    tick();
    check("reset vld", 128'(msg_sim_vld_o), 128'd0);
    check("reset done", 128'(msg_done_pluse_o), 128'd0);
    check("reset data", msg_sim_data_o, 128'd0);
    rst_n_i = 1'b1;
    tick();

    foreach (vecs[i]) run_frame(vecs[i]);

    // Retrigger: an identical second frame after en low then high again
    run_frame(vecs[0]);

    // Abort during payload: field_len=64 gives four payload beats
    apply_cfg(vecs[0]);
    sim_data_field_len = 16'd64;
    msg_sim_en_i = 1'b1;
    tick();  // start edge
    tick();  // header
    check("abort header vld", 128'(msg_sim_vld_o), 128'd1);
    tick();  // payload beat 0
    check("abort beat0", msg_sim_data_o, 128'h00010203_04050607_08090a0b_0c0d0e0f);
    msg_sim_en_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("abort cyc%0d vld/done", i),
            {126'd0, msg_sim_vld_o, msg_done_pluse_o}, 128'd0);
      check($sformatf("abort cyc%0d data", i), msg_sim_data_o, 128'd0);
    end

    // Asynchronous reset in the middle of a payload burst
    msg_sim_en_i = 1'b1;
    tick();  // start edge
    tick();  // header
    tick();  // beat 0
    check("prereset vld", 128'(msg_sim_vld_o), 128'd1);
    #2;
    rst_n_i = 1'b0;
    msg_sim_en_i = 1'b0;
    #1;
    check("async rst vld/done", {126'd0, msg_sim_vld_o, msg_done_pluse_o}, 128'd0);
    check("async rst data", msg_sim_data_o, 128'd0);
    tick();
    rst_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post rst cyc%0d vld/done", i),
            {126'd0, msg_sim_vld_o, msg_done_pluse_o}, 128'd0);
    end

    // Sequencer must be back in idle and accept a fresh frame
    run_frame(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
